// File: rtl/regb_fifo_lvl.sv
// ============================================================================
// Module      : regb_fifo_lvl
// Description : Register-based first-word-fall-through FIFO with fill level,
//               almost-full/empty flags, flush and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regb_fifo_lvl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AF_TH = 6,
    parameter int AE_TH = 2,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [WIDTH-1:0] wdata,
    input  logic             shift_in,
    input  logic             shift_out,
    input  logic             flush,
    input  logic             err_clr,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;

    logic             w_rd;
    logic             w_wr;
    logic [LW-1:0]    w_widx;

    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(DEPTH));
    assign almost_empty = (level_q <= LW'(AE_TH));
    assign almost_full  = (level_q >= LW'(AF_TH));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    // Slots above the level are always zero, so the head reads zero when empty.
    assign rdata        = mem_q[0];

    assign w_rd   = shift_out & ~empty;
    assign w_wr   = shift_in & (~full | shift_out);
    assign w_widx = level_q - LW'(w_rd);

    always_comb begin
        mem_d       = mem_q;
        level_d     = level_q;
        overflow_d  = (overflow_q  & ~err_clr) | (shift_in & full & ~shift_out & ~flush);
        underflow_d = (underflow_q & ~err_clr) | (shift_out & empty & ~flush);

        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_d[k] = '0;
            end
            level_d = '0;
        end else begin
            if (w_rd) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    mem_d[k] = mem_q[k + 1];
                end
                mem_d[DEPTH-1] = '0;
            end
            // Write lands in the first free slot after any shift this cycle.
            if (w_wr) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (w_widx == LW'(k)) begin
                        mem_d[k] = wdata;
                    end
                end
            end
            level_d = level_q + LW'(w_wr) - LW'(w_rd);
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regb_fifo_lvl.sv
// ============================================================================
// Module      : tb_regb_fifo_lvl
// Description : Directed, table-driven self-checking bench for regb_fifo_lvl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regb_fifo_lvl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AF_TH = 6;
    localparam int AE_TH = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             res_n;
    logic [WIDTH-1:0] wdata;
    logic             shift_in;
    logic             shift_out;
    logic             flush;
    logic             err_clr;
    logic [WIDTH-1:0] rdata;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    int n_cmp;
    int n_bad;

    regb_fifo_lvl #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AF_TH (AF_TH),
        .AE_TH (AE_TH)
    ) dut (
        .clk          (clk),
        .res_n        (res_n),
        .wdata        (wdata),
        .shift_in     (shift_in),
        .shift_out    (shift_out),
        .flush        (flush),
        .err_clr      (err_clr),
        .rdata        (rdata),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       si;
        logic       so;
        logic       fl;
        logic       ec;
        logic [7:0] wd;
        int         lvl;
        logic [7:0] rd;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic si, logic so, logic fl, logic ec, logic [7:0] wd,
                                int lvl, logic [7:0] rd, logic ovf, logic udf);
        vec_t v;
        v.si = si; v.so = so; v.fl = fl; v.ec = ec; v.wd = wd;
        v.lvl = lvl; v.rd = rd; v.ovf = ovf; v.udf = udf;
        vq.push_back(v);
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, int lvl, logic [7:0] rd, logic ovf, logic udf);
        check({tag, " level"},        int'(level),        lvl);
        check({tag, " rdata"},        int'(rdata),        int'(rd));
        check({tag, " empty"},        int'(empty),        int'(lvl == 0));
        check({tag, " full"},         int'(full),         int'(lvl == DEPTH));
        check({tag, " almost_empty"}, int'(almost_empty), int'(lvl <= AE_TH));
        check({tag, " almost_full"},  int'(almost_full),  int'(lvl >= AF_TH));
        check({tag, " overflow"},     int'(overflow),     int'(ovf));
        check({tag, " underflow"},    int'(underflow),    int'(udf));
    endtask

    task automatic drive(logic si, logic so, logic fl, logic ec, logic [7:0] wd);
        @(negedge clk);
        shift_in = si; shift_out = so; flush = fl; err_clr = ec; wdata = wd;
        @(posedge clk);
        #1;
        shift_in = 1'b0; shift_out = 1'b0; flush = 1'b0; err_clr = 1'b0; wdata = '0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        res_n = 1'b0;
        shift_in = 1'b0; shift_out = 1'b0; flush = 1'b0; err_clr = 1'b0; wdata = '0;

        // Three writes, then flush
        add(1,0,0,0,8'h11, 1,8'h11,0,0);
        add(1,0,0,0,8'h22, 2,8'h11,0,0);
        add(1,0,0,0,8'h33, 3,8'h11,0,0);
        add(0,0,1,0,8'h00, 0,8'h00,0,0);
        // Fill 01..08, overflow attempt, clear
        for (int i = 1; i <= 8; i++) add(1,0,0,0,8'(i), i,8'h01,0,0);
        add(1,0,0,0,8'h99, 8,8'h01,1,0);
        add(0,0,0,1,8'h00, 8,8'h01,0,0);
        // Write+read while full, then drain
        add(1,1,0,0,8'hAA, 8,8'h02,0,0);
        add(0,1,0,0,8'h00, 7,8'h03,0,0);
        add(0,1,0,0,8'h00, 6,8'h04,0,0);
        add(0,1,0,0,8'h00, 5,8'h05,0,0);
        add(0,1,0,0,8'h00, 4,8'h06,0,0);
        add(0,1,0,0,8'h00, 3,8'h07,0,0);
        add(0,1,0,0,8'h00, 2,8'h08,0,0);
        add(0,1,0,0,8'h00, 1,8'hAA,0,0);
        add(0,1,0,0,8'h00, 0,8'h00,0,0);
        // Underflow, then write+read on empty
        add(0,1,0,0,8'h00, 0,8'h00,0,1);
        add(1,1,0,0,8'h5C, 1,8'h5C,0,1);
        add(0,0,0,1,8'h00, 1,8'h5C,0,0);
        add(0,1,0,0,8'h00, 0,8'h00,0,0);
        add(0,1,0,1,8'h00, 0,8'h00,0,1);
        add(0,0,0,1,8'h00, 0,8'h00,0,0);
        // Load 5, flush with both shifts
        for (int i = 1; i <= 5; i++) add(1,0,0,0,8'(8'h40 + i), i,8'h41,0,0);
        add(1,1,1,0,8'h77, 0,8'h00,0,0);
        // Flush on full FIFO with lone write raises no overflow
        for (int i = 1; i <= 8; i++) add(1,0,0,0,8'(8'h60 + i), i,8'h61,0,0);
        add(1,0,1,0,8'hEE, 0,8'h00,0,0);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 8'h00, 0, 0);
        @(negedge clk);
        res_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].si, vq[i].so, vq[i].fl, vq[i].ec, vq[i].wd);
            check_all($sformatf("vec%0d", i), vq[i].lvl, vq[i].rd, vq[i].ovf, vq[i].udf);
        end

        // Async reset between edges discards contents at once
        for (int i = 1; i <= 4; i++) drive(1,0,0,0,8'(8'hC0 + i));
        check_all("pre_rst", 4, 8'hC1, 0, 0);
        drive(1,0,0,0,8'hFF);
        drive(0,1,0,0,8'h00);
        drive(1,0,0,0,8'hFF);
        drive(1,0,0,0,8'hFF);
        drive(1,0,0,0,8'hFF);
        drive(1,0,0,0,8'hFF);
        drive(1,0,0,0,8'hFF);
        drive(1,0,0,0,8'hFF);
        check_all("pre_rst_ovf", 8, 8'hC2, 1, 0);
        #2;
        res_n = 1'b0;
        #1;
        check_all("async_rst", 0, 8'h00, 0, 0);
        @(negedge clk);
        res_n = 1'b1;

        // Level walk 0..8 for threshold edges
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1,0,0,0,8'(8'h80 + i));
            check_all($sformatf("walk%0d", i), i, 8'h81, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regb_fifo_lvl.md
Name: regb_fifo_lvl

Overview:
- Register-based, first-word-fall-through FIFO with parameterised depth and width.
- Extends the plain shift FIFO with: fill-level output, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Used as a local elastic buffer between producer/consumer blocks that need early back-pressure and error visibility.
- Storage is a register array, not RAM. Entries shift toward the head on every read.

Parameters:
- DEPTH, 8: number of entries, >=2.
- WIDTH, 8: data bits per entry, >=1.
- AF_TH, 6: almost_full asserts when level >= AF_TH. Range 1..DEPTH.
- AE_TH, 2: almost_empty asserts when level <= AE_TH. Range 0..DEPTH-1.
- LW, $clog2(DEPTH+1): width of level (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- res_n  in  1  asynchronous active-low reset
- wdata  in  WIDTH  write data
- shift_in  in  1  write request
- shift_out  in  1  read request (pops the head)
- flush  in  1  synchronous clear of contents
- err_clr  in  1  synchronous clear of sticky error flags
- rdata  out  WIDTH  head entry (oldest)
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- almost_empty  out  1  level <= AE_TH
- almost_full  out  1  level >= AF_TH
- level  out  LW  number of valid entries
- overflow  out  1  sticky: write attempted while full without a simultaneous read
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock clk; reset res_n is asynchronous and active-low.
- Reset (res_n=0, asynchronous):
  - level=0, all storage registers=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=(AF_TH==0 → n/a, so 0), rdata=0.
- Status outputs are combinational decodes of the registered level.
- rdata is entry[0]. It reads all-zero whenever empty=1.
- Effective operations, evaluated per cycle:
  - rd = shift_out & ~empty.
  - wr = shift_in & (~full | shift_out).
  - A write to a full FIFO is accepted when shift_out is also asserted.
- Update at the clock edge (flush=0):
  - rd=1: entry[k] <= entry[k+1] for k=0..DEPTH-2; entry[DEPTH-1] <= 0.
  - wr=1: wdata is stored at index (level - rd), i.e. the first free slot after the shift.
  - level <= level + wr - rd.
  - Simultaneous wr and rd: level is unchanged, and the data order is preserved.
- Latency:
  - A write into an empty FIFO appears on rdata the cycle after the write edge.
  - A read presents the next entry on rdata the cycle after the read edge.
- flush=1:
  - level <= 0 and all entries <= 0.
  - shift_in and shift_out are ignored that cycle, and raise no errors.
  - flush has priority over every other input except reset.
- Errors:
  - overflow <= 1 when shift_in & full & ~shift_out & ~flush.
  - underflow <= 1 when shift_out & empty & ~flush.
  - Rejected operations do not change level or storage.
  - Both flags stay set until err_clr=1 or reset.
  - err_clr clears both flags. If a new error occurs in the same cycle as err_clr, the set wins.
- Shift_out while empty together with shift_in: the write is accepted (level becomes 1) and underflow is set.
- level never exceeds DEPTH and never wraps below 0.
- Reset asserted mid-operation discards all data immediately. After release, the FIFO behaves as freshly reset.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on consecutive cycles → level 1,2,3 on the following cycles; rdata=0x11 from the cycle after the first write; almost_empty deasserts when level=3.
- Fill 8 entries (0x01..0x08), then shift_in with 0x99 alone → full=1, level=8, overflow=1, contents unchanged; pulse err_clr → overflow=0.
- With full FIFO, assert shift_in (0xAA) and shift_out together → rdata goes 0x01→0x02, level stays 8, no overflow; pop 8 entries → last value read is 0xAA.
- On an empty FIFO, assert shift_out alone → underflow=1, level=0, rdata=0. Then shift_in+shift_out with 0x5C → level=1, rdata=0x5C.
- Load 5 entries, assert flush together with shift_in and shift_out → next cycle level=0, empty=1, rdata=0, no error flags.
- Load 4 entries, assert res_n=0 asynchronously between edges → outputs return to reset values immediately. Level walk 0..8: almost_full asserts exactly at 6; almost_empty deasserts exactly at 3.
